// File: rtl/lrf_axis_frame_rx.sv
// rtl/lrf_axis_frame_rx.sv - AXIS image beat receiver: frame/row/col tagging, beat FIFO, tlast checking
// Optional build macro LRF_RX_LANE_REVERSE_EN reverses pixel lanes between s_axis_tdata and out_data.
module lrf_axis_frame_rx #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int FIFO_DEPTH      = 4,
  localparam int DW   = PIXEL_WIDTH * PIXELS_PER_BEAT,
  localparam int COLS = IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int RW   = $clog2(IMAGE_DIM),
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          s_axis_aclk,
  input  logic          s_axis_areset,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic [15:0]   frame_cnt,
  output logic          err_tlast_early,
  output logic          err_tlast_miss
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + RW + CW + 3;

  typedef enum logic {ST_IDLE, ST_RECV} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic          tready_q, tready_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          err_early_q, err_early_d;
  logic          err_miss_q, err_miss_d;

  logic          push, pop;
  logic          last_col, last_row, last_beat;
  logic          tag_sof, tag_eol, tag_eof;
  logic [DW-1:0] in_data;
  logic [EW-1:0] wr_entry;

`ifdef LRF_RX_LANE_REVERSE_EN
  for (genvar k = 0; k < PIXELS_PER_BEAT; k++) begin : g_lane
    assign in_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] =
      s_axis_tdata[(PIXELS_PER_BEAT-1-k)*PIXEL_WIDTH +: PIXEL_WIDTH];
  end
`else
  assign in_data = s_axis_tdata;
`endif

  // tready is registered so it is low in reset and only rises the cycle after a pop frees a full FIFO
  assign push      = s_axis_tvalid & tready_q;
  assign pop       = (count_q != '0) & out_ready;
  assign last_col  = (col_q == CW'(COLS - 1));
  assign last_row  = (row_q == RW'(IMAGE_DIM - 1));
  assign last_beat = last_col & last_row;
  assign tag_sof   = (row_q == '0) & (col_q == '0);
  assign tag_eol   = last_col;
  assign tag_eof   = last_beat | s_axis_tlast;
  assign wr_entry  = {in_data, row_q, col_q, tag_sof, tag_eol, tag_eof};

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_entry;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    tready_d = (count_d != (AW+1)'(FIFO_DEPTH));
  end

  // An early tlast closes the frame like a normal end, but does not count as a completed frame
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    frame_cnt_d = frame_cnt_q;
    err_early_d = push & s_axis_tlast & ~last_beat;
    err_miss_d  = push & last_beat & ~s_axis_tlast;
    if (push) begin
      if (last_beat || s_axis_tlast) begin
        row_d   = '0;
        col_d   = '0;
        state_d = ST_IDLE;
      end else if (last_col) begin
        col_d   = '0;
        row_d   = row_q + 1'b1;
        state_d = ST_RECV;
      end else begin
        col_d   = col_q + 1'b1;
        state_d = ST_RECV;
      end
      if (last_beat) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tready_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_early_q <= 1'b0;
      err_miss_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tready_q    <= tready_d;
      frame_cnt_q <= frame_cnt_d;
      err_early_q <= err_early_d;
      err_miss_q  <= err_miss_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign {out_data, out_row, out_col, out_sof, out_eol, out_eof} = mem_q[rd_ptr_q];
  assign out_valid       = (count_q != '0);
  assign s_axis_tready   = tready_q;
  assign frame_cnt       = frame_cnt_q;
  assign err_tlast_early = err_early_q;
  assign err_tlast_miss  = err_miss_q;

endmodule

// File: tb/tb_lrf_axis_frame_rx.sv
// tb/tb_lrf_axis_frame_rx.sv - directed bench for lrf_axis_frame_rx (32x32 frame, 2 beats/row, FIFO of 4)
module tb_lrf_axis_frame_rx;

  localparam logic [127:0] LANE_IN = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef LRF_RX_LANE_REVERSE_EN
  localparam logic [127:0] LANE_OUT = 128'h0f0e0d0c0b0a09080706050403020100;
`else
  localparam logic [127:0] LANE_OUT = 128'h000102030405060708090a0b0c0d0e0f;
`endif

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   row;
    logic         col;
    logic         sof;
    logic         eol;
    logic         eof;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_tdata;
  logic         s_tvalid, s_tlast, s_tready;
  logic [127:0] out_data;
  logic         out_valid, out_ready, out_sof, out_eol, out_eof;
  logic [4:0]   out_row;
  logic         out_col;
  logic [15:0]  frame_cnt;
  logic         err_tlast_early, err_tlast_miss;

  int   n_checks = 0;
  int   n_errors = 0;
  int   k_sent, n_total, tlast_idx, stream_id, pos;
  bit   src_en;
  bit   nxt_early, nxt_miss;
  int   early_cnt, miss_cnt;
  exp_t q[$];

  lrf_axis_frame_rx #(
    .PIXEL_WIDTH(8), .PIXELS_PER_BEAT(16), .IMAGE_DIM(32), .FIFO_DEPTH(4)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_row(out_row), .out_col(out_col), .frame_cnt(frame_cnt),
    .err_tlast_early(err_tlast_early), .err_tlast_miss(err_tlast_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_data(input int id, input int k);
    if (id == 0) return 128'(k);
    if (id == 9 && k == 0) return LANE_IN;
    return {16'(id), 112'(k)};
  endfunction

  task automatic drive();
    s_tvalid = src_en && (k_sent < n_total);
    s_tdata  = mk_data(stream_id, k_sent);
    s_tlast  = (k_sent == tlast_idx);
  endtask

  // Sampled at the falling edge: decides what the next rising edge accepts/pops
  task automatic tick();
    logic acc, pop;
    exp_t e;
    acc = s_tvalid && s_tready;
    pop = out_valid && out_ready;
    if (pop) begin
      if (q.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", out_data, e.data);
        chk("row", out_row, e.row);
        chk("col", out_col, e.col);
        chk("sof", out_sof, e.sof);
        chk("eol", out_eol, e.eol);
        chk("eof", out_eof, e.eof);
      end
    end
    nxt_early = 1'b0;
    nxt_miss  = 1'b0;
    if (acc) begin
      e.data = (s_tdata == LANE_IN) ? LANE_OUT : s_tdata;
      e.row  = 5'(pos >> 1);
      e.col  = pos[0];
      e.sof  = (pos == 0);
      e.eol  = pos[0];
      e.eof  = (pos == 63) || s_tlast;
      q.push_back(e);
      nxt_early = s_tlast && (pos != 63);
      nxt_miss  = !s_tlast && (pos == 63);
      pos = (s_tlast || pos == 63) ? 0 : pos + 1;
      k_sent++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("err_early", err_tlast_early, nxt_early);
    chk("err_miss", err_tlast_miss, nxt_miss);
    early_cnt += int'(err_tlast_early);
    miss_cnt  += int'(err_tlast_miss);
    drive();
  endtask

  task automatic start_stream(input int id, input int n, input int tl);
    stream_id = id;
    n_total   = n;
    tlast_idx = tl;
    k_sent    = 0;
    src_en    = 1'b1;
    drive();
  endtask

  task automatic finish_stream();
    for (int c = 0; c < 2000 && (k_sent < n_total || q.size() != 0); c++) tick();
    chk("stream_done", (k_sent == n_total) && (q.size() == 0), 1);
    src_en = 1'b0;
    drive();
    chk("drained_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; src_en = 1'b0;
    k_sent = 0; n_total = 0; tlast_idx = -1; stream_id = 0; pos = 0;
    early_cnt = 0; miss_cnt = 0;
    drive();
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_data", out_data, 0);
    chk("rst_errs", {err_tlast_early, err_tlast_miss}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", s_tready, 1);

    // Clean frame, data = index
    out_ready = 1'b1;
    start_stream(0, 64, 63);
    finish_stream();
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_no_errs", early_cnt + miss_cnt, 0);

    // Backpressure: FIFO fills to 4, tready recovers one cycle after the first pop
    out_ready = 1'b0;
    start_stream(2, 64, 63);
    repeat (8) tick();
    chk("t2_accepted", k_sent, 4);
    chk("t2_tready_full", s_tready, 0);
    chk("t2_valid_full", out_valid, 1);
    out_ready = 1'b1;
    chk("t2_tready_pop_cycle", s_tready, 0);
    tick();
    chk("t2_tready_after_pop", s_tready, 1);
    finish_stream();
    chk("t2_frame_cnt", frame_cnt, 2);

    // Early tlast on beat 20
    early_cnt = 0; miss_cnt = 0;
    start_stream(3, 21, 20);
    finish_stream();
    chk("t3_early_pulses", early_cnt, 1);
    chk("t3_frame_cnt", frame_cnt, 2);

    // Missing tlast: 64 beats plus one more that must open a new frame
    early_cnt = 0; miss_cnt = 0;
    start_stream(4, 65, -1);
    finish_stream();
    chk("t4_miss_pulses", miss_cnt, 1);
    chk("t4_early_pulses", early_cnt, 0);
    chk("t4_frame_cnt", frame_cnt, 3);

    // Reset mid-frame with beats still buffered
    start_stream(5, 29, -1);
    finish_stream();
    out_ready = 1'b0;
    start_stream(6, 2, -1);
    for (int c = 0; c < 20 && k_sent < n_total; c++) tick();
    chk("t5_buffered", out_valid, 1);
    src_en = 1'b0;
    drive();
    rst = 1'b1;
    q.delete();
    pos = 0;
    #1;
    chk("t5_rst_valid_async", out_valid, 0);
    chk("t5_rst_tready_async", s_tready, 0);
    @(negedge clk);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_tready", s_tready, 0);
    chk("t5_rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fresh frame after reset; beat 0 carries the lane-order pattern
    early_cnt = 0; miss_cnt = 0;
    out_ready = 1'b1;
    start_stream(9, 64, 63);
    finish_stream();
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_no_errs", early_cnt + miss_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
